// File: rtl/spi_led_ctrl_n_pkg.sv
// Shared constants and frame/status layouts for the SPI LED controller.
// Command opcodes, frame geometry and the abort counter ceiling live here.
package spi_led_ctrl_n_pkg;

   localparam int CMD_W       = 8;
   localparam int ADDR_W      = 8;
   localparam int PAYLOAD_W   = 8;
   localparam int FRAME_WIDTH = CMD_W + ADDR_W + PAYLOAD_W;

   localparam logic [CMD_W-1:0] CMD_NOP      = 8'h00;
   localparam logic [CMD_W-1:0] CMD_LED_SET  = 8'h01;
   localparam logic [CMD_W-1:0] CMD_LED_READ = 8'h02;
   localparam logic [CMD_W-1:0] CMD_SET_ALL  = 8'h03;
   localparam logic [CMD_W-1:0] CMD_STATUS   = 8'h04;

   localparam logic [5:0] STATUS_ABORT_MAX = 6'd63;

   typedef struct packed {
      logic [CMD_W-1:0]     cmd;
      logic [ADDR_W-1:0]    addr;
      logic [PAYLOAD_W-1:0] payload;
   } frame_t;

   typedef struct packed {
      logic       err_addr;
      logic       err_cmd;
      logic [5:0] abort_cnt;
   } status_t;

endpackage

// File: rtl/spi_led_ctrl_n_if.sv
// SPI pin bundle between the board-level master and the LED controller.
interface spi_led_ctrl_n_if;
   logic sclk;
   logic cs;
   logic mosi;
   logic miso;

   modport master (output sclk, output cs, output mosi, input miso);
   modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_led_ctrl_n_spi_slave_shifter.sv
// Oversampled SPI mode-0 slave: synchronisers, edge detect, rx/tx shifting,
// bit counting and abort detection. Frame interpretation is left to the parent.
module spi_slave_shifter
   import spi_led_ctrl_n_pkg::*;
(
   input  logic                   sysclk,
   input  logic                   rst_n,
   spi_led_ctrl_n_if.slave        spi,
   input  logic [7:0]             tx_byte,
   output frame_t                 frame,
   output logic [15:0]            hdr,
   output logic                   hdr_done,
   output logic                   frame_done,
   output logic                   abort
);

   localparam logic [4:0] CNT_FULL = 5'(FRAME_WIDTH);
   localparam logic [4:0] CNT_HDR  = 5'(CMD_W + ADDR_W);

   logic [2:0]             sclk_pipe_q, sclk_pipe_d;
   logic [2:0]             cs_pipe_q, cs_pipe_d;
   logic [1:0]             mosi_pipe_q, mosi_pipe_d;
   logic [4:0]             bit_cnt_q, bit_cnt_d;
   logic [FRAME_WIDTH-1:0] rx_q, rx_d;
   logic [7:0]             tx_q, tx_d;
   logic                   frame_done_q, frame_done_d;
   logic                   sclk_rise, sclk_fall, cs_low, cs_fall, cs_rise, sample;

   // bit [1] of each pipe is the synchronised level, bit [2] its previous value
   assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
   assign sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
   assign cs_low    = ~cs_pipe_q[1];
   assign cs_fall   = ~cs_pipe_q[1] & cs_pipe_q[2];
   assign cs_rise   = cs_pipe_q[1] & ~cs_pipe_q[2];
   assign sample    = sclk_rise & cs_low & (bit_cnt_q < CNT_FULL);

   assign hdr        = {rx_q[14:0], mosi_pipe_q[1]};
   assign hdr_done   = sample & (bit_cnt_q == CNT_HDR - 5'd1);
   assign abort      = cs_rise & (bit_cnt_q != 5'd0) & (bit_cnt_q < CNT_FULL);
   assign frame      = frame_t'(rx_q);
   assign frame_done = frame_done_q;
   // gate with the raw pin so miso drops the moment the master deselects us
   assign spi.miso   = tx_q[7] & ~spi.cs;

   always_comb begin
      sclk_pipe_d  = {sclk_pipe_q[1:0], spi.sclk};
      cs_pipe_d    = {cs_pipe_q[1:0], spi.cs};
      mosi_pipe_d  = {mosi_pipe_q[0], spi.mosi};
      bit_cnt_d    = bit_cnt_q;
      rx_d         = rx_q;
      tx_d         = tx_q;
      frame_done_d = sample & (bit_cnt_q == CNT_FULL - 5'd1);
      if (cs_fall) begin
         bit_cnt_d = '0;
         rx_d      = '0;
         tx_d      = '0;
      end else if (cs_rise) begin
         tx_d = '0;
      end else if (sample) begin
         rx_d      = {rx_q[FRAME_WIDTH-2:0], mosi_pipe_q[1]};
         bit_cnt_d = bit_cnt_q + 5'd1;
         if (hdr_done) tx_d = tx_byte;
      end else if (sclk_fall & cs_low & (bit_cnt_q > CNT_HDR) & (bit_cnt_q < CNT_FULL)) begin
         // the fall right after the 16th sample keeps payload bit 7 on the line
         tx_d = {tx_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_pipe_q  <= '0;
         cs_pipe_q    <= '1;
         mosi_pipe_q  <= '0;
         bit_cnt_q    <= '0;
         rx_q         <= '0;
         tx_q         <= '0;
         frame_done_q <= 1'b0;
      end else begin
         sclk_pipe_q  <= sclk_pipe_d;
         cs_pipe_q    <= cs_pipe_d;
         mosi_pipe_q  <= mosi_pipe_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_q         <= rx_d;
         tx_q         <= tx_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: rtl/spi_led_ctrl_n.sv
// SPI-controlled NUM_CH-channel PWM LED driver with broadcast, read-back and
// a sticky status register; commands execute when a full 24-bit frame lands.
module spi_led_ctrl_n
   import spi_led_ctrl_n_pkg::*;
#(
   parameter int NUM_CH   = 8,
   parameter int BRIGHT_W = 7,
   parameter int PWM_DIV  = 4
) (
   input  logic               sysclk,
   input  logic               rst_n,
   spi_led_ctrl_n_if.slave    spi,
   output logic [NUM_CH-1:0]  led,
   output logic               rx_dv
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PSC_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam logic [BRIGHT_W-1:0] PWM_TOP    = BRIGHT_W'((1 << BRIGHT_W) - 2);
   localparam logic [PSC_W-1:0]    PSC_RELOAD = PSC_W'(PWM_DIV - 1);

   frame_t              frame;
   logic [15:0]         hdr;
   logic                hdr_done, frame_done, abort;
   logic [7:0]          tx_byte;
   logic [BRIGHT_W-1:0] bright_q [NUM_CH];
   logic [BRIGHT_W-1:0] bright_d [NUM_CH];
   status_t             status_q, status_d;
   logic [PSC_W-1:0]    psc_q, psc_d;
   logic [BRIGHT_W-1:0] pwm_q, pwm_d;
   logic [NUM_CH-1:0]   led_q, led_d;
   logic [BRIGHT_W-1:0] pay_bright;
   logic                rd_ok, wr_ok;

   spi_slave_shifter u_shifter (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .spi        (spi),
      .tx_byte    (tx_byte),
      .frame      (frame),
      .hdr        (hdr),
      .hdr_done   (hdr_done),
      .frame_done (frame_done),
      .abort      (abort)
   );

   assign rx_dv = frame_done;
   assign led   = led_q;

   // response is built from the header as the 16th bit is being sampled
   always_comb begin
      tx_byte = '0;
      rd_ok   = {1'b0, hdr[7:0]} < 9'(NUM_CH);
      case (hdr[15:8])
         CMD_LED_READ: if (rd_ok) tx_byte = 8'(bright_q[hdr[IDX_W-1:0]]) << (8 - BRIGHT_W);
         CMD_STATUS:   tx_byte = status_q;
         default:      tx_byte = '0;
      endcase
   end

   always_comb begin
      bright_d   = bright_q;
      status_d   = status_q;
      pay_bright = frame.payload[7 -: BRIGHT_W];
      wr_ok      = {1'b0, frame.addr} < 9'(NUM_CH);
      if (frame_done) begin
         case (frame.cmd)
            CMD_NOP: ;
            CMD_LED_SET: begin
               if (wr_ok) bright_d[frame.addr[IDX_W-1:0]] = pay_bright;
               else       status_d.err_addr = 1'b1;
            end
            CMD_LED_READ: if (!wr_ok) status_d.err_addr = 1'b1;
            CMD_SET_ALL: for (int i = 0; i < NUM_CH; i++) bright_d[i] = pay_bright;
            CMD_STATUS:  status_d = '0;
            default:     status_d.err_cmd = 1'b1;
         endcase
      end
      if (abort && status_d.abort_cnt != STATUS_ABORT_MAX)
         status_d.abort_cnt = status_d.abort_cnt + 6'd1;
   end

   always_comb begin
      psc_d = psc_q - 1'b1;
      pwm_d = pwm_q;
      if (psc_q == '0) begin
         psc_d = PSC_RELOAD;
         pwm_d = (pwm_q == PWM_TOP) ? '0 : pwm_q + 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++) led_d[i] = pwm_q < bright_q[i];
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) bright_q[i] <= '0;
         status_q <= '0;
         psc_q    <= PSC_RELOAD;
         pwm_q    <= '0;
         led_q    <= '0;
      end else begin
         bright_q <= bright_d;
         status_q <= status_d;
         psc_q    <= psc_d;
         pwm_q    <= pwm_d;
         led_q    <= led_d;
      end
   end

endmodule
